// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared widths, loader state encoding and program word type
package gpu_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } load_state_t;

  typedef logic [DATA_W-1:0] prog_word_t;

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - small synchronous skid FIFO with occupancy count
module loader_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);
  import gpu_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and count; simultaneous write and read leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program image from memory into the frame store
module prog_loader #(
  parameter int ADDR_W = gpu_pkg::ADDR_W,
  parameter int DATA_W = gpu_pkg::DATA_W,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_cke,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [DATA_W-1:0] word_data,
  output logic [ADDR_W-1:0] word_index,
  output logic              prog_loading,
  output logic              done
);
  import gpu_pkg::*;

  localparam int FD = RD_LAT + 2;
  localparam int CW = $clog2(FD + 1);
  localparam int SW = CW + 1;
  localparam int LW = ADDR_W + 1;

  load_state_t              state;
  load_state_t              state_nx;
  logic [LW-1:0]            len;
  logic [LW-1:0]            len_clip;
  logic [LW-1:0]            issued;
  logic [LW-1:0]            accepted;
  logic [ADDR_W-1:0]        addr_q;
  logic [RD_LAT-1:0]        pipe_v;
  logic [ADDR_W-1:0]        pipe_idx [RD_LAT];
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            inflight;
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_out;
  logic                     credit_ok;
  logic                     issue;
  logic                     take;

  assign len_clip   = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign word_valid = !fifo_empty;
  assign take       = word_valid && word_ready;
  assign word_data  = fifo_out[DATA_W-1:0];
  assign word_index = fifo_out[ADDR_W+DATA_W-1:DATA_W];
  assign mem_rd     = issue;
  assign mem_addr   = issue ? issued[ADDR_W-1:0] : addr_q;
  assign credit_ok  = (SW'(fifo_count) + SW'(inflight)) < SW'(FD);

  // Count reads still travelling through the memory latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // Next-state and strobes: issue only while credit remains, finish after the last accept.
  always_comb begin
    state_nx     = state;
    issue        = 1'b0;
    done         = 1'b0;
    prog_loading = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (prog_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        prog_loading = 1'b1;
        issue        = credit_ok && (issued < len);
        if (issue && (issued + 1'b1 == len)) state_nx = DRAIN;
      end
      DRAIN: begin
        prog_loading = 1'b1;
        if (take && (accepted + 1'b1 == len)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, transfer length and issue/accept counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      accepted <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len      <= len_clip;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) begin
          issued <= issued + 1'b1;
          addr_q <= issued[ADDR_W-1:0];
        end
        if (take) accepted <= accepted + 1'b1;
      end
    end
  end

  // Valid pipe mirrors memory latency so returning data lands with its frame index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= issue;
      pipe_idx[0] <= issued[ADDR_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Memory clock enable rises on the first edge after reset and stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_cke <= 1'b0;
    else          mem_cke <= 1'b1;
  end

  loader_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FD)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (pipe_v[RD_LAT-1]),
    .wr_data ({pipe_idx[RD_LAT-1], mem_data}),
    .rd_en   (take),
    .rd_data (fifo_out),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
